// File: rtl/fdc_pkg.sv
// fdc_pkg: shared RDW constants, clear FSM state type and byte-lane merge helper for the FDC sector RAM.
package fdc_pkg;
    localparam int RDW_WRITE_FIRST = 0;
    localparam int RDW_READ_FIRST  = 1;
    localparam int MERGE_W         = 256;

    typedef enum logic {CLEAR, RUN} clr_state_e;

    // Callers zero-extend to MERGE_W and truncate the result back to their own width.
    function automatic logic [MERGE_W-1:0] byte_merge(
        input logic [MERGE_W-1:0]   old_w,
        input logic [MERGE_W-1:0]   new_w,
        input logic [MERGE_W/8-1:0] be
    );
        byte_merge = old_w;
        for (int i = 0; i < MERGE_W / 8; i++)
            if (be[i]) byte_merge[i*8 +: 8] = new_w[i*8 +: 8];
    endfunction
endpackage

// File: rtl/fdc_tdp_ram_if.sv
// fdc_tdp_ram_if: both RAM ports plus busy, master = client side, slave = RAM side.
interface fdc_tdp_ram_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10
);
    logic                  cea, ceb, ocea, oceb, busy;
    logic [DATA_W/8-1:0]   wrea, wreb;
    logic [ADDR_W-1:0]     ada, adb;
    logic [DATA_W-1:0]     dina, dinb, douta, doutb;

    modport master (
        output cea, ceb, wrea, wreb, ada, adb, dina, dinb, ocea, oceb,
        input  douta, doutb, busy
    );
    modport slave (
        input  cea, ceb, wrea, wreb, ada, adb, dina, dinb, ocea, oceb,
        output douta, doutb, busy
    );
endinterface

// File: rtl/fdc_tdp_ram_clr.sv
// fdc_tdp_ram_clr: CLEAR/RUN FSM sweeping the whole array with the init pattern after reset.
module fdc_tdp_ram_clr
    import fdc_pkg::*;
#(
    parameter int ADDR_W         = 10,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              reset,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);
    clr_state_e      state_q;
    logic [ADDR_W:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
            cnt_q   <= '0;
        end else if (state_q == CLEAR) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q[ADDR_W-1:0] == '1) state_q <= RUN;
        end
    end

    // The reset cycle itself never writes, so a mid-clear reset leaves the array untouched.
    assign busy     = state_q == CLEAR;
    assign clr_we   = busy && !reset;
    assign clr_addr = cnt_q[ADDR_W-1:0];
endmodule

// File: rtl/fdc_tdp_ram.sv
// fdc_tdp_ram: single-clock true dual-port RAM with byte lanes, RDW policy, optional output register
// and a reset-time clear sequencer muxed into port A.
module fdc_tdp_ram
    import fdc_pkg::*;
#(
    parameter int              DATA_W         = 8,
    parameter int              ADDR_W         = 10,
    parameter int              RDW_MODE       = RDW_WRITE_FIRST,
    parameter int              OUT_REG        = 0,
    parameter int              CLEAR_ON_RESET = 1,
    parameter logic [DATA_W-1:0] INIT_VAL     = '0
) (
    input logic           clk,
    input logic           reset,
    fdc_tdp_ram_if.slave  bus
);
    localparam int NB = DATA_W / 8;

    logic              busy, clr_we, acc_a, acc_b;
    logic [ADDR_W-1:0] clr_addr, ad_a;
    logic [NB-1:0]     we_a, we_b;
    logic [DATA_W-1:0] din_a, old_a, old_b, s1a_d, s1b_d, s1a_q, s1b_q;
    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    fdc_tdp_ram_clr #(.ADDR_W(ADDR_W), .CLEAR_ON_RESET(CLEAR_ON_RESET)) u_clr (
        .clk(clk), .reset(reset), .busy(busy), .clr_we(clr_we), .clr_addr(clr_addr)
    );

    always_comb begin
        acc_a = bus.cea && !busy && !reset;
        acc_b = bus.ceb && !busy && !reset;
        we_a  = clr_we ? '1 : (acc_a ? bus.wrea : '0);
        we_b  = acc_b ? bus.wreb : '0;
        ad_a  = clr_we ? clr_addr : bus.ada;
        din_a = clr_we ? INIT_VAL : bus.dina;
        old_a = mem_q[bus.ada];
        old_b = mem_q[bus.adb];
        s1a_d = (RDW_MODE == RDW_READ_FIRST) ? old_a
              : DATA_W'(byte_merge(MERGE_W'(old_a), MERGE_W'(bus.dina), (MERGE_W/8)'(bus.wrea)));
        s1b_d = (RDW_MODE == RDW_READ_FIRST) ? old_b
              : DATA_W'(byte_merge(MERGE_W'(old_b), MERGE_W'(bus.dinb), (MERGE_W/8)'(bus.wreb)));
    end

    // Port A is written last so it owns any byte lane both ports enable on the same address.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (we_b[i]) mem_q[bus.adb][i*8 +: 8] <= bus.dinb[i*8 +: 8];
            if (we_a[i]) mem_q[ad_a][i*8 +: 8] <= din_a[i*8 +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1a_q <= '0;
            s1b_q <= '0;
        end else begin
            if (acc_a) s1a_q <= s1a_d;
            if (acc_b) s1b_q <= s1b_d;
        end
    end

    if (OUT_REG != 0) begin : g_oreg
        logic [DATA_W-1:0] douta_q, doutb_q;
        always_ff @(posedge clk) begin
            if (reset) begin
                douta_q <= '0;
                doutb_q <= '0;
            end else begin
                if (!busy && bus.ocea) douta_q <= s1a_q;
                if (!busy && bus.oceb) doutb_q <= s1b_q;
            end
        end
        assign bus.douta = douta_q;
        assign bus.doutb = doutb_q;
    end else begin : g_noreg
        assign bus.douta = s1a_q;
        assign bus.doutb = s1b_q;
    end

    assign bus.busy = busy;
endmodule

// File: tb/tb_fdc_tdp_ram.sv
// tb_fdc_tdp_ram: scoreboard bench driving a write-first/no-outreg RAM and a read-first/outreg RAM in lockstep.
module tb_fdc_tdp_ram;
    localparam logic [15:0] INIT = 16'hE5E5;

    typedef struct {
        int          due;
        string       nm;
        logic [15:0] val;
    } chk_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    chk_t q [6][$];
    chk_t e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fdc_tdp_ram_if #(.DATA_W(16), .ADDR_W(4)) b0 ();
    fdc_tdp_ram_if #(.DATA_W(16), .ADDR_W(4)) b1 ();

    assign b1.cea  = b0.cea;
    assign b1.ceb  = b0.ceb;
    assign b1.wrea = b0.wrea;
    assign b1.wreb = b0.wreb;
    assign b1.ada  = b0.ada;
    assign b1.adb  = b0.adb;
    assign b1.dina = b0.dina;
    assign b1.dinb = b0.dinb;
    assign b1.ocea = b0.ocea;
    assign b1.oceb = b0.oceb;

    fdc_tdp_ram #(.DATA_W(16), .ADDR_W(4), .RDW_MODE(0), .OUT_REG(0), .CLEAR_ON_RESET(1), .INIT_VAL(INIT))
        d0 (.clk(clk), .reset(reset), .bus(b0));
    fdc_tdp_ram #(.DATA_W(16), .ADDR_W(4), .RDW_MODE(1), .OUT_REG(1), .CLEAR_ON_RESET(1), .INIT_VAL(INIT))
        d1 (.clk(clk), .reset(reset), .bus(b1));

    // Channels: 0/1 = d0 douta/doutb, 2/3 = d1 douta/doutb, 4/5 = d0/d1 busy.
    function automatic logic [15:0] outval(input int c);
        case (c)
            0:       return b0.douta;
            1:       return b0.doutb;
            2:       return b1.douta;
            3:       return b1.doutb;
            4:       return {15'd0, b0.busy};
            default: return {15'd0, b1.busy};
        endcase
    endfunction

    always @(negedge clk) begin
        for (int c = 0; c < 6; c++) begin
            while (q[c].size() != 0 && q[c][0].due <= cyc) begin
                e = q[c].pop_front();
                checks++;
                if (e.due != cyc || outval(c) !== e.val) begin
                    errors++;
                    $display("FAIL %s ch%0d cyc%0d: got %h want %h", e.nm, c, cyc, outval(c), e.val);
                end
            end
        end
    end

    task automatic drv(input logic ca, input logic [1:0] wa, input logic [3:0] aa, input logic [15:0] da,
                       input logic cb, input logic [1:0] wb, input logic [3:0] ab, input logic [15:0] dbv,
                       input logic oa);
        b0.cea  = ca;
        b0.wrea = wa;
        b0.ada  = aa;
        b0.dina = da;
        b0.ceb  = cb;
        b0.wreb = wb;
        b0.adb  = ab;
        b0.dinb = dbv;
        b0.ocea = oa;
        b0.oceb = 1'b1;
    endtask

    task automatic expect_at(input int ch, input int lat, input string nm, input logic [15:0] v);
        q[ch].push_back('{due: cyc + lat, nm: nm, val: v});
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic busy_cycle(input string nm, input logic b);
        for (int c = 0; c < 4; c++) expect_at(c, 1, {nm, "_dout"}, 16'h0);
        expect_at(4, 1, {nm, "_busy"}, {15'd0, b});
        expect_at(5, 1, {nm, "_busy"}, {15'd0, b});
    endtask

    task automatic read_all(input string nm);
        for (int i = 0; i < 16; i++) begin
            drv(1'b1, 2'b00, i[3:0], 16'h0, 1'b1, 2'b00, 4'(15 - i), 16'h0, 1'b1);
            expect_at(0, 1, nm, INIT);
            expect_at(1, 1, nm, INIT);
            expect_at(2, 2, nm, INIT);
            expect_at(3, 2, nm, INIT);
            expect_at(4, 1, {nm, "_busy"}, 16'h0);
            expect_at(5, 1, {nm, "_busy"}, 16'h0);
            step();
        end
    endtask

    initial begin
        drv(1'b0, 2'b00, 4'd0, 16'h0, 1'b0, 2'b00, 4'd0, 16'h0, 1'b1);
        step();
        busy_cycle("reset", 1'b1);
        step();
        reset = 1'b0;
        // Port B hammers address 0 throughout the clear; it must be ignored.
        for (int i = 1; i <= 16; i++) begin
            drv(1'b0, 2'b00, 4'd0, 16'h0, 1'b1, 2'b11, 4'd0, 16'h1234, 1'b1);
            busy_cycle("clear", i < 16);
            step();
        end
        read_all("clear_rd");

        drv(1'b1, 2'b11, 4'd3, 16'hBEEF, 1'b0, 2'b00, 4'd0, 16'h0, 1'b1);
        expect_at(0, 1, "lane_wr1", 16'hBEEF);
        expect_at(2, 2, "lane_wr1", INIT);
        step();
        drv(1'b1, 2'b10, 4'd3, 16'h1200, 1'b0, 2'b00, 4'd0, 16'h0, 1'b1);
        expect_at(0, 1, "lane_wr2", 16'h12EF);
        expect_at(2, 2, "lane_wr2", 16'hBEEF);
        step();
        drv(1'b1, 2'b00, 4'd3, 16'h0, 1'b1, 2'b00, 4'd3, 16'h0, 1'b1);
        for (int c = 0; c < 4; c++) expect_at(c, (c < 2) ? 1 : 2, "lane_rd", 16'h12EF);
        step();

        drv(1'b1, 2'b11, 4'd5, 16'h1111, 1'b0, 2'b00, 4'd0, 16'h0, 1'b1);
        expect_at(0, 1, "rdw_pre", 16'h1111);
        expect_at(2, 2, "rdw_pre", INIT);
        step();
        drv(1'b1, 2'b11, 4'd5, 16'h2222, 1'b1, 2'b00, 4'd5, 16'h0, 1'b1);
        expect_at(0, 1, "rdw_wf", 16'h2222);
        expect_at(1, 1, "rdw_xport", 16'h1111);
        expect_at(2, 2, "rdw_rf", 16'h1111);
        expect_at(3, 2, "rdw_xport", 16'h1111);
        step();
        drv(1'b1, 2'b00, 4'd5, 16'h0, 1'b1, 2'b00, 4'd5, 16'h0, 1'b1);
        for (int c = 0; c < 4; c++) expect_at(c, (c < 2) ? 1 : 2, "rdw_rd", 16'h2222);
        step();

        drv(1'b1, 2'b01, 4'd7, 16'hAAAA, 1'b1, 2'b11, 4'd7, 16'hBBBB, 1'b1);
        expect_at(0, 1, "coll_a", 16'hE5AA);
        expect_at(1, 1, "coll_b", 16'hBBBB);
        expect_at(2, 2, "coll_a", INIT);
        expect_at(3, 2, "coll_b", INIT);
        step();
        drv(1'b1, 2'b00, 4'd7, 16'h0, 1'b1, 2'b00, 4'd7, 16'h0, 1'b1);
        for (int c = 0; c < 4; c++) expect_at(c, (c < 2) ? 1 : 2, "coll_rd", 16'hBBAA);
        step();

        drv(1'b1, 2'b00, 4'd7, 16'h0, 1'b0, 2'b00, 4'd0, 16'h0, 1'b1);
        expect_at(0, 1, "oreg_rd7", 16'hBBAA);
        step();
        drv(1'b0, 2'b00, 4'd0, 16'h0, 1'b0, 2'b00, 4'd0, 16'h0, 1'b1);
        expect_at(0, 1, "oreg_hold0", 16'hBBAA);
        expect_at(2, 1, "oreg_load7", 16'hBBAA);
        step();
        drv(1'b1, 2'b00, 4'd3, 16'h0, 1'b0, 2'b00, 4'd0, 16'h0, 1'b0);
        expect_at(0, 1, "oreg_rd3", 16'h12EF);
        expect_at(2, 1, "oreg_hold", 16'hBBAA);
        step();
        for (int i = 0; i < 2; i++) begin
            drv(1'b0, 2'b00, 4'd0, 16'h0, 1'b0, 2'b00, 4'd0, 16'h0, 1'b0);
            expect_at(0, 1, "oreg_hold0", 16'h12EF);
            expect_at(2, 1, "oreg_hold", 16'hBBAA);
            step();
        end
        drv(1'b0, 2'b00, 4'd0, 16'h0, 1'b0, 2'b00, 4'd0, 16'h0, 1'b1);
        expect_at(2, 1, "oreg_load3", 16'h12EF);
        step();

        // Mid-operation reset, then a second reset while the clear counter sits at address 9.
        reset = 1'b1;
        drv(1'b0, 2'b00, 4'd0, 16'h0, 1'b0, 2'b00, 4'd0, 16'h0, 1'b1);
        busy_cycle("rst_op", 1'b1);
        step();
        reset = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            busy_cycle("clr_part", 1'b1);
            step();
        end
        reset = 1'b1;
        drv(1'b1, 2'b11, 4'd9, 16'h1234, 1'b0, 2'b00, 4'd0, 16'h0, 1'b1);
        busy_cycle("rst_mid", 1'b1);
        step();
        reset = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            busy_cycle("clear2", i < 16);
            step();
        end
        read_all("clear2_rd");

        drv(1'b0, 2'b00, 4'd0, 16'h0, 1'b0, 2'b00, 4'd0, 16'h0, 1'b1);
        repeat (3) step();
        for (int c = 0; c < 6; c++) begin
            checks++;
            if (q[c].size() != 0) begin
                errors++;
                $display("FAIL drain ch%0d: %0d pending, want 0", c, q[c].size());
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
